intt_gs_butterfly_pipe: RTL and testbench
=========================================

INTT_GS_BUTTERFLY_PIPE -- requirements
Module: intt_gs_butterfly_pipe

Interface
REQ-001 The block SHALL have parameter N, default 17, giving the coefficient and twiddle width in bits.
REQ-002 The block SHALL have parameter Q, default 65537, giving the prime modulus, with Q < 2^N.
REQ-003 The block SHALL have parameter TAGW, default 8, giving the width of the sideband tag.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: an operand set is offered.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts the offered set this cycle.
REQ-008 The block SHALL have port a, input, N bits: upper butterfly operand, in [0, Q-1].
REQ-009 The block SHALL have port b, input, N bits: lower butterfly operand, in [0, Q-1].
REQ-010 The block SHALL have port tf, input, N bits: inverse twiddle factor, in [0, Q-1].
REQ-011 The block SHALL have port halve, input, 1 bit: multiply both results by 2^-1 mod Q.
REQ-012 The block SHALL have port in_tag, input, TAGW bits: opaque index, carried to the output with its data.
REQ-013 The block SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-014 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-015 The block SHALL have port x, output, N bits: (a+b) mod Q, halved if requested.
REQ-016 The block SHALL have port y, output, N bits: ((a-b)·tf) mod Q, halved if requested.
REQ-017 The block SHALL have port out_tag, output, TAGW bits: the in_tag of the presented result.

Function
REQ-018 A transfer SHALL occur on an edge where valid and ready are both high, on either side.
REQ-019 The pipeline SHALL have three register stages (S1 add/sub, S2 multiply, S3 reduce/halve/output), each with a valid bit.
REQ-020 The advance signal SHALL equal (~out_valid | out_ready), and in_ready SHALL equal advance, combinationally.
REQ-021 When advance=1, all stages SHALL shift by one and S1 SHALL load the input, with valid = in_valid.
REQ-022 When advance=0, every stage register and every output SHALL hold its value.
REQ-023 Latency from input transfer to out_valid SHALL be exactly 3 cycles when advance stays 1.
REQ-024 Throughput SHALL be one result per cycle while out_ready=1.
REQ-025 S1 SHALL compute the sum as a+b, minus Q if the result is ≥ Q.
REQ-026 S1 SHALL compute the difference as a-b, plus Q if the result is negative, using N+1 bit intermediates and no overflow.
REQ-027 S2 SHALL form the full 2N-bit product diff·tf and carry the S1 sum forward unchanged.
REQ-028 S3 SHALL reduce the product to the exact value in [0, Q-1]; the reduction method is free, but the result SHALL be bit-exact.
REQ-029 When halve=1, S3 SHALL map each result v to v/2 if v is even, else (v+Q)/2.
REQ-030 halve and in_tag SHALL travel with their own operand set, never with a neighbour's.
REQ-031 Results SHALL leave in acceptance order, with no loss and no duplication under any out_ready pattern.
REQ-032 While out_valid=1 and out_ready=0, x, y and out_tag SHALL stay stable.
REQ-033 Bubbles (in_valid=0 on transfer cycles) SHALL propagate as invalid stages and SHALL NOT produce out_valid.
REQ-034 Operands ≥ Q SHALL give unspecified data but SHALL NOT corrupt the handshake or other transactions.

Reset
REQ-035 When rst_n=0, all stage valids, out_valid, x, y and out_tag SHALL go to 0 immediately, independent of clk.
REQ-036 A reset asserted mid-stream SHALL discard all in-flight transactions; after release, the first output SHALL come from the first new transfer.
REQ-037 in_ready SHALL be 1 during and after reset, since out_valid=0.

Verification
REQ-038 a=5, b=3, tf=2, halve=0, tag=0x11, out_ready=1 -> 3 cycles later: x=8, y=4, out_tag=0x11.
REQ-039 a=3, b=5, tf=1 -> x=8, y=65535; a=0, b=1, tf=65536 -> x=1, y=1 (wrap on diff and product).
REQ-040 a=65536, b=65536, tf=65536 -> x=65535, y=0; a=5, b=2, tf=1, halve=1 -> x=32772, y=32770.
REQ-041 Four back-to-back transfers, out_ready=0 for 5 cycles once out_valid rises -> in_ready=0, outputs stable, then all four results in order with no gap after out_ready=1.
REQ-042 rst_n pulsed low with three transactions in flight -> out_valid=0 at once, those three never appear, and a new transfer after release appears 3 cycles later.
REQ-043 Random stream (10k sets, random in_valid/out_ready/halve) against a modular-arithmetic reference -> every x, y and out_tag matches, in order.

Source files
------------

// File: rtl/intt_gs_butterfly_pipe.sv
// Inverse-NTT Gentleman-Sande butterfly: x = a+b, y = (a-b)*tf, both mod Q, optional halving.
// Three-stage pipeline (add/sub, multiply, reduce/halve) that stalls as a whole on backpressure.
module intt_gs_butterfly_pipe #(
    parameter int N    = 17,
    parameter int Q    = 65537,
    parameter int TAGW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    a,
    input  logic [N-1:0]    b,
    input  logic [N-1:0]    tf,
    input  logic            halve,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    x,
    output logic [N-1:0]    y,
    output logic [TAGW-1:0] out_tag
);

    localparam logic [N:0]     Q_N1 = (N+1)'(Q);
    localparam logic [2*N-1:0] Q_2N = (2*N)'(Q);

    // Handshake: a word moves on a rising edge where valid && ready. The whole pipe
    // advances when the output register is empty or being taken, so in_ready == advance.
    logic advance;

    logic            s1_valid_q, s1_valid_d;
    logic [N-1:0]    s1_sum_q, s1_sum_d;
    logic [N-1:0]    s1_diff_q, s1_diff_d;
    logic [N-1:0]    s1_tf_q, s1_tf_d;
    logic            s1_halve_q, s1_halve_d;
    logic [TAGW-1:0] s1_tag_q, s1_tag_d;

    logic            s2_valid_q, s2_valid_d;
    logic [N-1:0]    s2_sum_q, s2_sum_d;
    logic [2*N-1:0]  s2_prod_q, s2_prod_d;
    logic            s2_halve_q, s2_halve_d;
    logic [TAGW-1:0] s2_tag_q, s2_tag_d;

    logic            out_valid_q, out_valid_d;
    logic [N-1:0]    x_q, x_d;
    logic [N-1:0]    y_q, y_d;
    logic [TAGW-1:0] out_tag_q, out_tag_d;

    logic [N:0] sum_wide;
    logic [N:0] diff_wide;
    logic [N-1:0] y_red;

    // Multiplying by 2^-1 mod Q: odd values first get Q added so the shift is exact.
    function automatic logic [N-1:0] halve_mod(input logic [N-1:0] v);
        return N'(({1'b0, v} + (v[0] ? Q_N1 : '0)) >> 1);
    endfunction

    assign advance  = ~out_valid_q | out_ready;
    assign in_ready = advance;

    always_comb begin
        sum_wide  = {1'b0, a} + {1'b0, b};
        diff_wide = {1'b0, a} - {1'b0, b};
        y_red     = N'(s2_prod_q % Q_2N);

        s1_valid_d  = s1_valid_q;
        s1_sum_d    = s1_sum_q;
        s1_diff_d   = s1_diff_q;
        s1_tf_d     = s1_tf_q;
        s1_halve_d  = s1_halve_q;
        s1_tag_d    = s1_tag_q;
        s2_valid_d  = s2_valid_q;
        s2_sum_d    = s2_sum_q;
        s2_prod_d   = s2_prod_q;
        s2_halve_d  = s2_halve_q;
        s2_tag_d    = s2_tag_q;
        out_valid_d = out_valid_q;
        x_d         = x_q;
        y_d         = y_q;
        out_tag_d   = out_tag_q;

        if (advance) begin
            s1_valid_d = in_valid;
            s1_sum_d   = N'((sum_wide >= Q_N1) ? (sum_wide - Q_N1) : sum_wide);
            // Borrow out of the N+1 bit subtraction marks a negative difference.
            s1_diff_d  = N'(diff_wide[N] ? (diff_wide + Q_N1) : diff_wide);
            s1_tf_d    = tf;
            s1_halve_d = halve;
            s1_tag_d   = in_tag;

            s2_valid_d = s1_valid_q;
            s2_sum_d   = s1_sum_q;
            s2_prod_d  = (2*N)'(s1_diff_q) * (2*N)'(s1_tf_q);
            s2_halve_d = s1_halve_q;
            s2_tag_d   = s1_tag_q;

            out_valid_d = s2_valid_q;
            x_d         = s2_halve_q ? halve_mod(s2_sum_q) : s2_sum_q;
            y_d         = s2_halve_q ? halve_mod(y_red) : y_red;
            out_tag_d   = s2_tag_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_diff_q   <= '0;
            s1_tf_q     <= '0;
            s1_halve_q  <= 1'b0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_sum_q    <= '0;
            s2_prod_q   <= '0;
            s2_halve_q  <= 1'b0;
            s2_tag_q    <= '0;
            out_valid_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            out_tag_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_diff_q   <= s1_diff_d;
            s1_tf_q     <= s1_tf_d;
            s1_halve_q  <= s1_halve_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_sum_q    <= s2_sum_d;
            s2_prod_q   <= s2_prod_d;
            s2_halve_q  <= s2_halve_d;
            s2_tag_q    <= s2_tag_d;
            out_valid_q <= out_valid_d;
            x_q         <= x_d;
            y_q         <= y_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign x         = x_q;
    assign y         = y_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_intt_gs_butterfly_pipe.sv
// Bench for intt_gs_butterfly_pipe: directed vectors, stall, mid-stream reset and a random
// stream, all scored against a plain modular-arithmetic model through an expected queue.
module tb_intt_gs_butterfly_pipe;
    localparam int     N    = 17;
    localparam int     Q    = 65537;
    localparam int     TAGW = 8;
    localparam int     W    = 2*N + TAGW;
    localparam longint INV2 = (Q + 1) / 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    a, b, tf;
    logic            halve;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    x, y;
    logic [TAGW-1:0] out_tag;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic rand_ready = 1'b0;

    intt_gs_butterfly_pipe #(.N(N), .Q(Q), .TAGW(TAGW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .tf(tf), .halve(halve), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .x(x), .y(y), .out_tag(out_tag)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: x = (a+b) mod Q, y = (a-b)*tf mod Q, optionally times the inverse of 2.
    function automatic logic [W-1:0] model(input longint av, input longint bv, input longint tv,
                                           input logic h, input logic [TAGW-1:0] tg);
        longint xv, yv;
        xv = (av + bv) % Q;
        yv = ((av + Q - bv) * tv) % Q;
        if (h) begin
            xv = (xv * INV2) % Q;
            yv = (yv * INV2) % Q;
        end
        return {N'(xv), N'(yv), tg};
    endfunction

    function automatic logic [W-1:0] pack_exp(input logic [N-1:0] xv, input logic [N-1:0] yv,
                                              input logic [TAGW-1:0] tg);
        return {xv, yv, tg};
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv, input logic [N-1:0] tv,
                        input logic h, input logic [TAGW-1:0] tg, input logic [W-1:0] e);
        int   guard;
        logic done;
        guard = 0;
        done  = 1'b0;
        a = av; b = bv; tf = tv; halve = h; in_tag = tg;
        in_valid = 1'b1;
        while (!done && guard < 200) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                done = 1'b1;
            end
            tick();
            guard++;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no in_ready, expected in_ready within 200 cycles");
        end
    endtask

    // Called right after the accepting edge; out_valid must appear on the third edge.
    task automatic check_latency(input string name);
        int lat;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check(name, 64'(lat), 64'd3);
    endtask

    task automatic drain();
        int g;
        g = 0;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        in_valid   = 1'b0;
        while (exp_q.size() != 0 && g < 500) begin
            tick();
            g++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        idle(2);
    endtask

    // scoreboard monitor
    logic         held_v = 1'b0;
    logic [W-1:0] held_d;

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) check("stall_stable", {out_valid, x, y, out_tag}, {1'b1, held_d});
            held_v = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: got %0h, expected no output", {x, y, out_tag});
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", {x, y, out_tag}, e);
                end
            end else if (out_valid) begin
                held_v = 1'b1;
                held_d = {x, y, out_tag};
            end
        end
    end

    initial begin
        logic [N-1:0]    ra, rb, rt;
        logic            rh;
        logic [TAGW-1:0] rg;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; tf = '0; halve = 1'b0; in_tag = '0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_tag", out_tag, 0);
        check("rst_in_ready", in_ready, 1);
        #5 rst_n = 1'b1;
        tick();

        // directed vectors with hand-derived results
        out_ready = 1'b1;
        send(17'd5, 17'd3, 17'd2, 1'b0, 8'h11, pack_exp(17'd8, 17'd4, 8'h11));
        check_latency("latency_first");
        drain();
        send(17'd3, 17'd5, 17'd1, 1'b0, 8'h21, pack_exp(17'd8, 17'd65535, 8'h21));
        send(17'd0, 17'd1, 17'd65536, 1'b0, 8'h22, pack_exp(17'd1, 17'd1, 8'h22));
        send(17'd65536, 17'd65536, 17'd65536, 1'b0, 8'h23, pack_exp(17'd65535, 17'd0, 8'h23));
        send(17'd5, 17'd2, 17'd1, 1'b1, 8'h24, pack_exp(17'd32772, 17'd32770, 8'h24));
        drain();

        // four back-to-back, then a five-cycle stall once results are present
        for (int i = 0; i < 4; i++) begin
            ra = N'($urandom_range(0, Q-1)); rb = N'($urandom_range(0, Q-1));
            rt = N'($urandom_range(0, Q-1)); rh = 1'($urandom_range(0, 1));
            rg = TAGW'(8'h40 + i);
            send(ra, rb, rt, rh, rg, model(ra, rb, rt, rh, rg));
        end
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("release_no_gap", out_valid, 1);
            tick();
        end
        drain();

        // reset with three transactions in flight
        for (int i = 0; i < 3; i++) begin
            ra = N'($urandom_range(0, Q-1)); rb = N'($urandom_range(0, Q-1));
            rt = N'($urandom_range(0, Q-1));
            rg = TAGW'(8'h60 + i);
            send(ra, rb, rt, 1'b0, rg, model(ra, rb, rt, 1'b0, rg));
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_x", x, 0);
        check("midrst_y", y, 0);
        check("midrst_tag", out_tag, 0);
        check("midrst_in_ready", in_ready, 1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send(17'd100, 17'd40, 17'd3, 1'b0, 8'h77, pack_exp(17'd140, 17'd180, 8'h77));
        check_latency("latency_after_reset");
        drain();

        // random stream with random bubbles and backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            ra = N'($urandom_range(0, Q-1)); rb = N'($urandom_range(0, Q-1));
            rt = N'($urandom_range(0, Q-1)); rh = 1'($urandom_range(0, 1));
            rg = TAGW'($urandom_range(0, 255));
            send(ra, rb, rt, rh, rg, model(ra, rb, rt, rh, rg));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
